// File: rtl/psg_bus_arbiter.sv
// psg_bus_arbiter: round-robin sharing of the YM2149 register bus between two requesters.
module psg_bus_arbiter #(
   parameter int PHASE_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_wr,
   input  logic [3:0] req0_addr,
   input  logic [7:0] req0_data,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_data,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_wr,
   input  logic [3:0] req1_addr,
   input  logic [7:0] req1_data,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_data,
   output logic       psg_bdir,
   output logic       psg_bc,
   output logic [7:0] psg_di,
   input  logic [7:0] psg_do,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;
   localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);
   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       last_grant, gid, go, cap, id_q, wr_q;
   logic [3:0] addr_q;
   logic [7:0] data_q;
   always_comb begin
      go = req0_valid | req1_valid;
      gid = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
      cap = state == GAP2 && cnt == LAST && !wr_q;
      state_nx = state;
      cnt_nx = cnt - 4'd1;
      if (state == IDLE) begin
         cnt_nx = go ? LAST : cnt;
         state_nx = go ? ADDR : IDLE;
      end else if (cnt == 4'd0) begin
         cnt_nx = LAST;
         state_nx = (state == GAP2) ? IDLE : state_t'(state + 3'd1);
      end
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         cnt <= 4'd0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   end
   // Pins follow the state register by one clock, so ADDR appears the cycle after the ready pulse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_grant <= 1'b1;
         id_q <= 1'b0;
         wr_q <= 1'b0;
         addr_q <= 4'h0;
         data_q <= 8'h00;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data <= 8'h00;
         rsp1_data <= 8'h00;
         psg_bdir <= 1'b0;
         psg_bc <= 1'b0;
         psg_di <= 8'h00;
         busy <= 1'b0;
      end else begin
         req0_ready <= state == IDLE && go && !gid;
         req1_ready <= state == IDLE && go && gid;
         if (state == IDLE && go) begin
            id_q <= gid;
            wr_q <= gid ? req1_wr : req0_wr;
            addr_q <= gid ? req1_addr : req0_addr;
            data_q <= gid ? req1_data : req0_data;
            last_grant <= gid;
         end
         psg_bdir <= state == ADDR || (state == DATA && wr_q);
         psg_bc <= state == ADDR || (state == DATA && !wr_q);
         psg_di <= state == ADDR ? {4'h0, addr_q} :
                   state == GAP1 ? psg_di :
                   (state == DATA && wr_q) ? data_q : 8'h00;
         busy <= state != IDLE;
         rsp0_valid <= cap && !id_q;
         rsp1_valid <= cap && id_q;
         if (cap && !id_q) rsp0_data <= psg_do;
         if (cap && id_q) rsp1_data <= psg_do;
      end
   end
endmodule

// File: tb/tb_psg_bus_arbiter.sv
// tb_psg_bus_arbiter: directed scoreboard bench for psg_bus_arbiter at PHASE_CYCLES 2 and 1.
module tb_psg_bus_arbiter;
   typedef struct packed {
      logic       bdir, bc;
      logic [7:0] di;
      logic       busy, rv0, rv1;
      logic [7:0] rd;
   } beat_t;
   logic       CLK, RESET_N;
   logic       v0, v1, w0, w1;
   logic [3:0] a0, a1;
   logic [7:0] d0, d1, psg_do;
   int         sel, tests, fails, cyc, last_rdy;
   logic       rdy0[2], rdy1[2], rv0[2], rv1[2], bdir[2], bc[2], busy[2];
   logic [7:0] di[2], rd0[2], rd1[2];
   beat_t      q[$];

   psg_bus_arbiter #(.PHASE_CYCLES(2)) dut_a (
      .CLK(CLK), .RESET_N(RESET_N),
      .req0_valid(v0 && sel == 0), .req0_ready(rdy0[0]), .req0_wr(w0), .req0_addr(a0), .req0_data(d0),
      .rsp0_valid(rv0[0]), .rsp0_data(rd0[0]),
      .req1_valid(v1 && sel == 0), .req1_ready(rdy1[0]), .req1_wr(w1), .req1_addr(a1), .req1_data(d1),
      .rsp1_valid(rv1[0]), .rsp1_data(rd1[0]),
      .psg_bdir(bdir[0]), .psg_bc(bc[0]), .psg_di(di[0]), .psg_do(psg_do), .busy(busy[0]));

   psg_bus_arbiter #(.PHASE_CYCLES(1)) dut_b (
      .CLK(CLK), .RESET_N(RESET_N),
      .req0_valid(v0 && sel == 1), .req0_ready(rdy0[1]), .req0_wr(w0), .req0_addr(a0), .req0_data(d0),
      .rsp0_valid(rv0[1]), .rsp0_data(rd0[1]),
      .req1_valid(v1 && sel == 1), .req1_ready(rdy1[1]), .req1_wr(w1), .req1_addr(a1), .req1_data(d1),
      .rsp1_valid(rv1[1]), .rsp1_data(rd1[1]),
      .psg_bdir(bdir[1]), .psg_bc(bc[1]), .psg_di(di[1]), .psg_do(psg_do), .busy(busy[1]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   initial cyc = 0;
   always @(negedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int i, input int p, input logic [7:0] dov);
      beat_t b;
      @(negedge CLK);
      b = q.pop_front();
      chk("bdir", bdir[sel], b.bdir);
      chk("bc", bc[sel], b.bc);
      chk("di", di[sel], b.di);
      chk("busy", busy[sel], b.busy);
      chk("ready0_low", rdy0[sel], 0);
      chk("ready1_low", rdy1[sel], 0);
      chk("rsp0_valid", rv0[sel], b.rv0);
      chk("rsp1_valid", rv1[sel], b.rv1);
      if (b.rv0) chk("rsp0_data", rd0[sel], b.rd);
      if (b.rv1) chk("rsp1_data", rd1[sel], b.rd);
      psg_do = (i == 3 * p - 1) ? dov : ~dov;
   endtask

   task automatic xact(input int exp_id, input logic wr, input logic [3:0] addr, input logic [7:0] data,
                       input logic [7:0] dov, input int gap, input bit drop, input int nbeats);
      int p, id, ph;
      beat_t b;
      p = (sel == 1) ? 1 : 2;
      for (int n = 0; n < 40 && !(rdy0[sel] | rdy1[sel]); n++) @(negedge CLK);
      chk("ready_seen", rdy0[sel] | rdy1[sel], 1);
      chk("ready_onehot", rdy0[sel] & rdy1[sel], 0);
      id = rdy1[sel] ? 1 : 0;
      chk("grant_id", 8'(id), 8'(exp_id));
      if (gap > 0) chk("grant_gap", 8'(cyc - last_rdy), 8'(gap));
      last_rdy = cyc;
      if (drop) begin
         v0 = 1'b0;
         v1 = 1'b0;
      end
      psg_do = ~dov;
      for (int i = 0; i < 4 * p; i++) begin
         ph = i / p;
         b = '0;
         b.busy = 1'b1;
         b.bdir = ph == 0 || (ph == 2 && wr);
         b.bc = ph == 0 || (ph == 2 && !wr);
         b.di = ph < 2 ? {4'h0, addr} : (ph == 2 && wr) ? data : 8'h00;
         b.rv0 = !wr && i == 3 * p && exp_id == 0;
         b.rv1 = !wr && i == 3 * p && exp_id == 1;
         b.rd = dov;
         q.push_back(b);
      end
      for (int i = 0; i < nbeats; i++) step(i, p, dov);
      if (nbeats == 4 * p) begin
         @(negedge CLK);
         chk("idle_busy", busy[sel], 0);
         chk("idle_bdir", bdir[sel], 0);
         chk("idle_bc", bc[sel], 0);
         chk("idle_di", di[sel], 8'h00);
      end
   endtask

   initial begin
      tests = 0; fails = 0; sel = 0; last_rdy = 0;
      v0 = 0; v1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; psg_do = 8'h00;
      RESET_N = 1'b1;
      #1 RESET_N = 1'b0;
      #20;
      chk("rst_ready0", rdy0[0], 0);
      chk("rst_ready1", rdy1[0], 0);
      chk("rst_rsp0_valid", rv0[0], 0);
      chk("rst_rsp1_valid", rv1[0], 0);
      chk("rst_rsp0_data", rd0[0], 8'h00);
      chk("rst_rsp1_data", rd1[0], 8'h00);
      chk("rst_bdir", bdir[0], 0);
      chk("rst_bc", bc[0], 0);
      chk("rst_di", di[0], 8'h00);
      chk("rst_busy", busy[0], 0);
      @(negedge CLK) RESET_N = 1'b1;
      @(negedge CLK);
      // single write from requester 0
      w0 = 1; a0 = 4'd7; d0 = 8'h3E; v0 = 1;
      xact(0, 1, 4'd7, 8'h3E, 8'h00, 0, 1, 8);
      // read from requester 1; requester 0 response must stay untouched
      w1 = 0; a1 = 4'd14; d1 = 8'h99; v1 = 1;
      xact(1, 0, 4'd14, 8'h00, 8'hA5, 0, 1, 8);
      chk("rsp0_untouched", rd0[0], 8'h00);
      chk("rsp1_held", rd1[0], 8'hA5);
      // continuous contention alternates grants
      w0 = 1; a0 = 4'd1; d0 = 8'h11; w1 = 0; a1 = 4'd2; v0 = 1; v1 = 1;
      xact(0, 1, 4'd1, 8'h11, 8'h00, 0, 0, 8);
      xact(1, 0, 4'd2, 8'h00, 8'h5A, 9, 0, 8);
      xact(0, 1, 4'd1, 8'h11, 8'h00, 9, 0, 8);
      xact(1, 0, 4'd2, 8'h00, 8'hC7, 9, 1, 8);
      // reset in the middle of a write DATA phase
      w0 = 1; a0 = 4'd3; d0 = 8'hC3; v0 = 1;
      xact(0, 1, 4'd3, 8'hC3, 8'h00, 0, 1, 5);
      chk("mid_data_bdir", bdir[0], 1);
      #2 RESET_N = 1'b0;
      #1;
      chk("async_bdir", bdir[0], 0);
      chk("async_bc", bc[0], 0);
      chk("async_di", di[0], 8'h00);
      chk("async_busy", busy[0], 0);
      q.delete();
      @(negedge CLK) RESET_N = 1'b1;
      @(negedge CLK);
      chk("post_rst_busy", busy[0], 0);
      chk("post_rst_ready0", rdy0[0], 0);
      w0 = 0; a0 = 4'd9; w1 = 0; a1 = 4'd10; v0 = 1; v1 = 1;
      xact(0, 0, 4'd9, 8'h00, 8'h3C, 0, 1, 8);
      // single-clock phases
      sel = 1;
      w0 = 1; a0 = 4'd13; d0 = 8'h0E; w1 = 1; a1 = 4'd5; d1 = 8'h77; v0 = 1; v1 = 1;
      xact(0, 1, 4'd13, 8'h0E, 8'h00, 0, 0, 4);
      xact(1, 1, 4'd5, 8'h77, 8'h00, 5, 1, 4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/psg_bus_arbiter.md
Name: psg_bus_arbiter

Overview:
- Shares the YM2149 PSG register bus between two requesters, e.g. the CPU/VIA path and an autonomous sound sequencer.
- Arbitrates each register read or write transaction round-robin.
- Drives the PSG BDIR/BC/DI pins through the latch-address, inactive, data, inactive sequence, with a programmable phase length.
- For reads, captures PSG DO and returns it only to the requester that issued the read.

Parameters:
- PHASE_CYCLES, 2, clocks each bus phase lasts. Legal range 1..15.

Ports:
- CLK  in  1  global clock
- RESET_N  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a transaction
- req0_ready  out  1  requester 0 transaction accepted this cycle
- req0_wr  in  1  1 = write, 0 = read
- req0_addr  in  4  PSG register index
- req0_data  in  8  write data
- rsp0_valid  out  1  read data valid pulse
- rsp0_data  out  8  read data
- req1_valid, req1_ready, req1_wr, req1_addr, req1_data, rsp1_valid, rsp1_data: same as requester 0, for requester 1
- psg_bdir  out  1  PSG BDIR
- psg_bc  out  1  PSG BC
- psg_di  out  8  PSG data in
- psg_do  in  8  PSG data out
- busy  out  1  transaction in flight

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE, phase counter=0, last_grant=1.
  - psg_bdir=0, psg_bc=0, psg_di=0x00.
  - reqN_ready=0, rspN_valid=0, rspN_data=0x00, busy=0.
  - Reset mid-transaction aborts at once: the bus goes inactive, no response is issued, and the request is lost.
- All outputs are registered.
- Arbitration (IDLE only):
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant. After reset, requester 0 wins first.
  - On grant, pulse the granted reqN_ready for 1 cycle. Latch wr/addr/data and the grant id. Set last_grant to the grant id. Set busy=1.
  - reqN_ready is never high outside IDLE. Requesters hold valid and payload stable until they see ready.
- FSM states: IDLE -> ADDR -> GAP1 -> DATA -> GAP2 -> IDLE.
  - Each non-IDLE state lasts exactly PHASE_CYCLES clocks, timed by a 4-bit down-counter.
  - ADDR: bdir=1, bc=1, di={4'h0, addr}.
  - GAP1: bdir=0, bc=0, di held.
  - DATA, write: bdir=1, bc=0, di=data.
  - DATA, read: bdir=0, bc=1, di=0x00.
  - GAP2: bdir=0, bc=0, di=0x00.
  - Leaving GAP2: busy=0, and the FSM can grant a new request the same cycle it re-enters IDLE.
- Read capture: sample psg_do on the last clock of DATA into rspN_data of the granting requester. rspN_valid pulses 1 cycle on the following clock (the first GAP2 cycle). The other requester's rsp outputs are unchanged.
- Writes produce no response.
- Timing:
  - Ready pulse at cycle T; ADDR is driven from T+1.
  - The transaction occupies 4*PHASE_CYCLES clocks after T.
  - Back-to-back throughput is one transaction per 4*PHASE_CYCLES+1 clocks.
- Address width: the upper address nibble is always driven 0, so every transaction targets registers 0..15.
- Simultaneous events:
  - A requester deasserting valid while not granted has no effect.
  - A new valid during busy waits; it is arbitrated again in IDLE against the other requester under the round-robin rule.
- Invariant: bdir and bc are both 1 only in ADDR. The FSM never goes from ADDR to DATA without a GAP1 phase.

Test Plan:
- Single write: req0 wr addr=7 data=0x3E, PHASE_CYCLES=2 -> ready0 one pulse. Bus sequence (1,1,di=0x07)x2, (0,0)x2, (1,0,di=0x3E)x2, (0,0)x2. busy high for 8 clocks. No rsp.
- Read: req1 read addr=14, psg_do=0xA5 during DATA -> (1,1,di=0x0E)x2, gap, (0,1)x2. rsp1_valid pulses 1 clock with rsp1_data=0xA5. rsp0 untouched.
- Contention: both valid continuously from reset -> grants alternate 0,1,0,1. Each ready pulse is 9 clocks apart (PHASE_CYCLES=2).
- Reset mid-DATA of a write: assert RESET_N low -> psg_bdir/bc drop to 0 asynchronously. After release, state is IDLE, busy=0, and requester 0 wins the next contention.
- PHASE_CYCLES=1: write addr=13 data=0x0E -> each phase lasts 1 clock. Total busy is 4 clocks and the next grant comes 5 clocks after the previous one.
